// File: rtl/pipelined_addsub.sv
// Carry-segmented pipelined signed adder/subtractor with a valid/ready handshake.
// Each stage resolves one SEG-bit slice using the carry registered by the previous stage.
module pipelined_addsub #(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  localparam int MSB  = WIDTH - 1;

  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] a_d  [STAGES];
  logic [WIDTH-1:0] bp_q [STAGES];
  logic [WIDTH-1:0] bp_d [STAGES];
  logic [WIDTH-1:0] r_q  [STAGES];
  logic [WIDTH-1:0] r_d  [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic ovf_q, ovf_d;

  // Index k of the *_p arrays is whatever feeds stage k.
  logic [WIDTH-1:0] a_p  [STAGES];
  logic [WIDTH-1:0] bp_p [STAGES];
  logic [WIDTH-1:0] r_p  [STAGES];
  logic [STAGES-1:0] v_p, c_p;
  logic [SEG:0] seg_sum [STAGES];
  logic msb_cin;
  logic advance;

  always_comb begin
    // Subtraction as a + ~b + ~cin keeps a - b - cin exact in two's complement.
    a_p[0]  = a;
    bp_p[0] = sub ? ~b : b;
    r_p[0]  = '0;
    v_p     = '0;
    c_p     = '0;
    v_p[0]  = in_valid;
    c_p[0]  = cin ^ sub;
    for (int k = 1; k < STAGES; k++) begin
      a_p[k]  = a_q[k-1];
      bp_p[k] = bp_q[k-1];
      r_p[k]  = r_q[k-1];
      v_p[k]  = v_q[k-1];
      c_p[k]  = c_q[k-1];
    end
  end

  always_comb begin
    v_d = '0;
    c_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, a_p[k][k*SEG +: SEG]} + {1'b0, bp_p[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_p[k]};
      a_d[k]  = a_p[k];
      bp_d[k] = bp_p[k];
      v_d[k]  = v_p[k];
      c_d[k]  = seg_sum[k][SEG];
      r_d[k]  = r_p[k];
      r_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
    end
    // Carry into the MSB recovered from the sum bit: s = a ^ b' ^ c_in.
    msb_cin = a_p[LAST][MSB] ^ bp_p[LAST][MSB] ^ r_d[LAST][MSB];
    ovf_d   = msb_cin ^ c_d[LAST];
    if (SATURATE != 0 && ovf_d) begin
      r_d[LAST] = a_p[LAST][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    end
  end

  assign in_ready = rst | out_ready | ~v_q[LAST];
  assign advance  = in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        bp_q[k] <= '0;
        r_q[k]  <= '0;
      end
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= a_d[k];
        bp_q[k] <= bp_d[k];
        r_q[k]  <= r_d[k];
      end
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = r_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed corner beats, stall/reset behaviour and
// randomized traffic on several width/depth/saturation configurations against an arithmetic model.
module tb_pipelined_addsub;

  localparam int NI = 6;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a, b;
  logic        cin, sub;
  logic [NI-1:0] iv, ordy;
  wire  [NI-1:0] ir, ov, co, of;
  wire  [31:0]   sm [NI];
  wire  [15:0]   sm16;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_addsub #(.WIDTH(32), .STAGES(4), .SATURATE(0)) u_base (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(co[0]),
    .overflow(of[0]));
  pipelined_addsub #(.WIDTH(32), .STAGES(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(co[1]),
    .overflow(of[1]));
  pipelined_addsub #(.WIDTH(32), .STAGES(1), .SATURATE(0)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]), .cout(co[2]),
    .overflow(of[2]));
  pipelined_addsub #(.WIDTH(32), .STAGES(8), .SATURATE(0)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov[3]), .out_ready(ordy[3]), .sum(sm[3]), .cout(co[3]),
    .overflow(of[3]));
  pipelined_addsub #(.WIDTH(32), .STAGES(32), .SATURATE(0)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov[4]), .out_ready(ordy[4]), .sum(sm[4]), .cout(co[4]),
    .overflow(of[4]));
  pipelined_addsub #(.WIDTH(16), .STAGES(4), .SATURATE(0)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv[5]), .in_ready(ir[5]), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ov[5]), .out_ready(ordy[5]), .sum(sm16), .cout(co[5]),
    .overflow(of[5]));
  assign sm[5] = {16'h0000, sm16};

  function automatic int cfg_w(input int i);
    return (i == 5) ? 16 : 32;
  endfunction

  function automatic int cfg_s(input int i);
    case (i)
      2:       return 1;
      3:       return 8;
      4:       return 32;
      default: return 4;
    endcase
  endfunction

  function automatic bit cfg_sat(input int i);
    return (i == 1);
  endfunction

  // Reference: exact signed arithmetic on integers, then wrap or clamp to the configured width.
  function automatic exp_t model(input int i, input logic [31:0] aa, input logic [31:0] bb,
                                 input logic ci, input logic su);
    exp_t   r;
    longint w    = longint'(cfg_w(i));
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(aa) & m;
    longint ub   = longint'(bb) & m;
    longint c1   = longint'(ci);
    longint sa   = (ua >= half) ? ua - (m + 1) : ua;
    longint sb   = (ub >= half) ? ub - (m + 1) : ub;
    longint ex   = su ? (sa - sb - c1) : (sa + sb + c1);
    r.o = (ex >= half) || (ex < -half);
    r.c = su ? (ua >= ub + c1) : (((ua + ub + c1) >> w) != 0);
    if (cfg_sat(i) && r.o) ex = (ex > 0) ? (half - 1) : -half;
    r.s = 32'(ex & m);
    return r;
  endfunction

  task automatic test_beat(input int i, input string name, input logic [31:0] aa,
                           input logic [31:0] bb, input logic ci, input logic su,
                           input logic [31:0] es, input logic ec, input logic eo);
    int lat = 0;
    bit done = 0;
    @(negedge clk);
    a = aa; b = bb; cin = ci; sub = su;
    iv[i] = 1'b1; ordy[i] = 1'b1;
    while (!done) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      iv[i] = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      #1;
      if (ov[i] || lat >= 64) done = 1;
    end
    n_checks++;
    if (lat != cfg_s(i)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, lat, cfg_s(i));
    end
    n_checks++;
    if (sm[i] !== es) begin
      n_fail++;
      $display("FAIL %s sum: got %h, want %h", name, sm[i], es);
    end
    n_checks++;
    if (co[i] !== ec) begin
      n_fail++;
      $display("FAIL %s cout: got %b, want %b", name, co[i], ec);
    end
    n_checks++;
    if (of[i] !== eo) begin
      n_fail++;
      $display("FAIL %s overflow: got %b, want %b", name, of[i], eo);
    end
  endtask

  task automatic test_reset();
    int guard = 0;
    rst = 1'b1; iv = '0; ordy = '1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (ov !== '0 || ir !== '1) begin
      n_fail++;
      $display("FAIL reset_flags: out_valid %b in_ready %b, want 000000 111111", ov, ir);
    end
    rst = 1'b0;
    // Fill the base pipe, stall it, then reset while stalled.
    a = 32'h1234_5678; b = 32'h0101_0101; cin = 1'b1; sub = 1'b0;
    iv[0] = 1'b1; ordy[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    #1;
    while (!ov[0] && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    n_checks++;
    if (ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_before_reset: in_ready %b out_valid %b, want 0 1", ir[0], ov[0]);
    end
    rst = 1'b1; #1;
    n_checks++;
    if (ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_during_reset: got %b, want 1", ir[0]);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_flags: out_valid %b in_ready %b, want 0 1", ov[0], ir[0]);
    end
    n_checks++;
    if (sm[0] !== 32'h0 || co[0] !== 1'b0 || of[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_data: sum %h cout %b ovf %b, want 0 0 0", sm[0], co[0], of[0]);
    end
    ordy[0] = 1'b1;
  endtask

  task automatic test_corners();
    test_beat(0, "max_plus_one", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    test_beat(1, "sat_max_plus_one", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    test_beat(0, "sub_52_31", 32'd52, 32'd31, 1'b0, 1'b1, 32'd21, 1'b1, 1'b0);
    test_beat(0, "min_minus_one", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    test_beat(1, "sat_min_minus_one", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
    test_beat(0, "seg_carry", 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    test_beat(0, "all_ones_plus_one", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    test_beat(0, "borrow_in", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);
    test_beat(2, "s1_add", 32'd100, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd100, 1'b1, 1'b0);
    test_beat(3, "s8_seg_carry", 32'h0FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
    test_beat(4, "s32_ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    test_beat(5, "w16_max_plus_one", 32'h0000_7FFF, 32'h1, 1'b0, 1'b0, 32'h0000_8000, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    int sent = 0;
    int cyc = 0;
    bit prev_stall = 0;
    logic [31:0] prev_sum = '0;
    while (got.size() < 8 && cyc < 80) begin
      @(negedge clk);
      iv[0]   = (sent < 8);
      ordy[0] = !(cyc >= 3 && cyc <= 5);
      a = 32'(sent); b = 32'(1000 * sent); cin = 1'b0; sub = 1'b0;
      #1;
      n_checks++;
      if (ir[0] !== (!ov[0] || ordy[0])) begin
        n_fail++;
        $display("FAIL b2b_in_ready cycle %0d: got %b, want %b", cyc, ir[0], !ov[0] || ordy[0]);
      end
      if (prev_stall) begin
        n_checks++;
        if (ov[0] !== 1'b1 || sm[0] !== prev_sum) begin
          n_fail++;
          $display("FAIL b2b_hold cycle %0d: valid %b sum %h, want 1 %h", cyc, ov[0], sm[0], prev_sum);
        end
      end
      prev_stall = ov[0] && !ordy[0];
      prev_sum   = sm[0];
      if (ov[0] && ordy[0]) got.push_back(sm[0]);
      if (iv[0] && ir[0]) sent++;
      cyc++;
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    n_checks++;
    if (got.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, want 8", got.size());
    end
    foreach (got[k]) begin
      n_checks++;
      if (got[k] !== 32'(1001 * k)) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: got %0d, want %0d", k, got[k], 1001 * k);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int spurious = 0;
    ordy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      iv[0] = 1'b1; a = 32'(111 * (k + 1)); b = 32'd1; cin = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    iv[0] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    n_checks++;
    if (ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_reset_valid: got %b, want 0", ov[0]);
    end
    repeat (10) begin
      @(negedge clk); #1;
      if (ov[0]) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL midflight_discard: %0d stale results emitted, want 0", spurious);
    end
    test_beat(0, "post_reset_sub", 32'd4561, 32'd89, 1'b0, 1'b1, 32'd4472, 1'b1, 1'b0);
  endtask

  task automatic test_random(input int i, input int nbeats);
    exp_t q[$];
    exp_t e;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < nbeats && cyc < nbeats * 8 + 200) begin
      @(negedge clk);
      cyc++;
      iv[i]   = (sent < nbeats) && ($urandom_range(0, 9) < 7);
      ordy[i] = ($urandom_range(0, 9) < 7);
      a = $urandom; b = $urandom;
      cin = 1'($urandom); sub = 1'($urandom);
      case ($urandom_range(0, 7))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      #1;
      n_checks++;
      if (ir[i] !== (!ov[i] || ordy[i])) begin
        n_fail++;
        $display("FAIL rand%0d_in_ready cycle %0d: got %b, want %b", i, cyc, ir[i], !ov[i] || ordy[i]);
      end
      if (ov[i] && ordy[i]) begin
        got++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand%0d_extra: got result %h, want none", i, sm[i]);
        end else begin
          e = q.pop_front();
          if (sm[i] !== e.s || co[i] !== e.c || of[i] !== e.o) begin
            n_fail++;
            $display("FAIL rand%0d_result beat %0d: got sum %h cout %b ovf %b, want %h %b %b",
                     i, got, sm[i], co[i], of[i], e.s, e.c, e.o);
          end
        end
      end
      if (iv[i] && ir[i]) begin
        q.push_back(model(i, a, b, cin, sub));
        sent++;
      end
    end
    iv[i] = 1'b0; ordy[i] = 1'b1;
    n_checks++;
    if (got != nbeats || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand%0d_complete: got %0d results (%0d pending), want %0d", i, got, q.size(), nbeats);
    end
  endtask

  initial begin
    rst = 1'b1; iv = '0; ordy = '1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_reset_midflight();
    test_random(0, 10000);
    for (int i = 1; i < NI; i++) test_random(i, 2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
